// File: rtl/spi_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_link_pkg
// Description : Shared types and defaults for the node-to-node SPI link.
//               Parity helper is compiled only with SPI_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_link_pkg;

  localparam int unsigned SPI_WIDTH_DEFAULT = 32;
  localparam int unsigned SPI_CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } rx_state_e;

`ifdef SPI_RX_PARITY_EN
  // Words up to PARITY_MAX_W bits; zero-extension does not change parity.
  localparam int unsigned PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/spi_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_buffer
// Description : Single-entry valid/ready holding register for received words.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_buffer
  import spi_link_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             consume_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign consume_o = valid_q & ready_i;

  // A load in the consume cycle wins, so the buffer refills without a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (consume_o) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign full_o  = valid_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_receiver
// Description : MSB-first SPI deserialiser with single-entry output buffer,
//               truncation and overrun flags. SPI_RX_PARITY_EN appends an
//               even-parity bit to each frame and adds parity_error.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_receiver
  import spi_link_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = SPI_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_error,
  output logic             overrun,
  output logic             busy
`ifdef SPI_RX_PARITY_EN
  ,
  output logic             parity_error
`endif
);

`ifdef SPI_RX_PARITY_EN
  localparam int unsigned C_FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned C_FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(C_FRAME_LEN - 1);

  rx_state_e        state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             frame_error_q;
  logic             overrun_q;

  logic             w_sample;
  logic             w_last;
  logic             w_par_ok;
  logic             w_full;
  logic             w_consume;
  logic             w_load;
  logic             w_overrun;
  logic [WIDTH-1:0] w_shift_nx;
  logic [WIDTH-1:0] w_word;

  assign w_sample   = cs & bit_en & (state_q != ST_DRAIN);
  assign w_last     = w_sample & (cnt_q == C_LAST_CNT);
  assign w_shift_nx = (shift_q << 1) | WIDTH'(sdi);

`ifdef SPI_RX_PARITY_EN
  // The parity bit is the final sample; the data word is already in shift_q.
  assign w_word   = shift_q;
  assign w_par_ok = (even_parity(PARITY_MAX_W'(shift_q)) == sdi);
`else
  assign w_word   = w_shift_nx;
  assign w_par_ok = 1'b1;
`endif

  assign w_load    = w_last & w_par_ok & (~w_full | w_consume);
  assign w_overrun = w_last & w_par_ok & w_full & ~w_consume;

  spi_rx_buffer #(
    .WIDTH (WIDTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (w_load),
    .data_i    (w_word),
    .ready_i   (data_ready),
    .data_o    (data_out),
    .valid_o   (data_valid),
    .full_o    (w_full),
    .consume_o (w_consume)
  );

`ifdef SPI_RX_PARITY_EN
  logic parity_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_error_q <= 1'b0;
    end else begin
      parity_error_q <= w_last & ~w_par_ok;
    end
  end

  assign parity_error = parity_error_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      if (w_sample) begin
        shift_q <= w_shift_nx;
      end
      unique case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (!cs) begin
            // cnt_q is always zero in IDLE, so only SHIFT can flag truncation.
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            frame_error_q <= (cnt_q != '0);
          end else if (w_overrun) begin
            state_q   <= ST_DRAIN;
            cnt_q     <= '0;
            overrun_q <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
            if (w_last) begin
              cnt_q <= '0;
            end else if (w_sample) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!cs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_receiver
// Description : Scoreboard bench for spi_slave_receiver (honours SPI_RX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_receiver;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
`ifdef SPI_RX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  typedef enum int {EV_FE = 0, EV_OVR = 1, EV_PE = 2} ev_e;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cs = 1'b0;
  logic             bit_en = 1'b0;
  logic             sdi = 1'b0;
  logic             data_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_error;
  logic             overrun;
  logic             busy;
`ifdef SPI_RX_PARITY_EN
  logic             parity_error;
`endif

  int               n_checks = 0;
  int               n_pass = 0;
  logic [WIDTH-1:0] exp_words[$];
  ev_e              exp_ev[$];
  bit               rand_ready = 1'b0;
  logic             ready_val = 1'b0;

  always #5 clk = ~clk;

  spi_slave_receiver #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .bit_en      (bit_en),
    .sdi         (sdi),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
`ifdef SPI_RX_PARITY_EN
    ,
    .parity_error (parity_error)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string msg);
    n_checks++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  task automatic chk_event(input ev_e got);
    if (exp_ev.size() == 0) fail_now($sformatf("event_unexpected: got %0d, expected none", int'(got)));
    else chk("event_kind", 64'(int'(got)), 64'(int'(exp_ev.pop_front())));
  endtask

  // Monitor: every handshake and every pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && data_ready) begin
        if (exp_words.size() == 0)
          fail_now($sformatf("word_unexpected: got 0x%08h, expected none", data_out));
        else
          chk("word", 64'(data_out), 64'(exp_words.pop_front()));
      end
      if (frame_error) chk_event(EV_FE);
      if (overrun)     chk_event(EV_OVR);
`ifdef SPI_RX_PARITY_EN
      if (parity_error) chk_event(EV_PE);
`endif
    end
  end

  // Consumer: later in the cycle than the driver so ready_val applies the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      data_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

`ifdef SPI_RX_PARITY_EN
  function automatic logic par_of(input logic [WIDTH-1:0] w);
    return 1'($countones(w) % 2);
  endfunction
`endif

  task automatic put_bit(input logic b, input int gap);
    repeat (gap) begin @(posedge clk); #1; bit_en = 1'b0; end
    @(posedge clk); #1;
    cs = 1'b1; bit_en = 1'b1; sdi = b;
  endtask

  task automatic end_bits();
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic cs_off();
    @(posedge clk); #1;
    cs = 1'b0; bit_en = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cs = 1'b0; bit_en = 1'($urandom_range(0, 1)); sdi = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int maxgap);
    for (int i = WIDTH - 1; i >= 0; i--) put_bit(w[i], $urandom_range(0, maxgap));
`ifdef SPI_RX_PARITY_EN
    put_bit(par_of(w), $urandom_range(0, maxgap));
`endif
    end_bits();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_words.size() != 0 || data_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending_words", 64'(exp_words.size()), 0);
    chk("drain_valid", 64'(data_valid), 0);
  endtask

  task automatic wait_buf_empty();
    int n = 0;
    while (data_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (data_valid) fail_now("buffer_timeout: got data_valid=1, expected 0 within 100 cycles");
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int kind, nbits, nw;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(data_valid), 0);
    chk("reset_data", 64'(data_out), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_pulses", 64'({frame_error, overrun}), 0);
    reset = 1'b0;

    // Single word: valid exactly one cycle after the last strobe, then consumed.
    ready_val = 1'b1;
    w = 32'hA5A5_0F0F;
    exp_words.push_back(w);
    send_word(w, 0);
    chk("single_valid_latency", 64'(data_valid), 1);
    chk("single_data", 64'(data_out), 64'(w));
    @(posedge clk); #1;
    chk("single_valid_one_cycle", 64'(data_valid), 0);
    cs_off();

    // Back-to-back with no consumer: second word overruns, FSM drains.
    ready_val = 1'b0;
    exp_words.push_back(32'h0000_0001);
    exp_ev.push_back(EV_OVR);
    send_word(32'h0000_0001, 0);
    send_word(32'h8000_0000, 0);
    chk("b2b_busy_drain", 64'(busy), 1);
    chk("b2b_hold", 64'(data_out), 64'h1);
    for (int i = 0; i < 5; i++) put_bit(1'b1, 0);
    end_bits();
    chk("b2b_drain_ignores", 64'(busy), 1);
    chk("b2b_hold_after", 64'(data_out), 64'h1);
    cs_off();
    @(posedge clk); #1;
    chk("b2b_idle", 64'(busy), 0);
    ready_val = 1'b1;
    wait_drain();

    // Truncated frame, then a good frame.
    for (int i = 0; i < 17; i++) put_bit(1'($urandom_range(0, 1)), 0);
    end_bits();
    exp_ev.push_back(EV_FE);
    cs_off();
    @(posedge clk); #1;
    chk("trunc_valid", 64'(data_valid), 0);
    chk("trunc_busy", 64'(busy), 0);
    exp_words.push_back(32'h1234_5678);
    send_word(32'h1234_5678, 1);
    cs_off();
    wait_drain();

    // Consume in the same cycle as the next word completes.
    ready_val = 1'b0;
    exp_words.push_back(32'h0000_0001);
    send_word(32'h0000_0001, 0);
    w = 32'hDEAD_BEEF;
    exp_words.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) put_bit(w[i], 0);
`ifdef SPI_RX_PARITY_EN
    put_bit(par_of(w), 0);
`endif
    ready_val = 1'b1;
    end_bits();
    ready_val = 1'b0;
    chk("simul_valid", 64'(data_valid), 1);
    chk("simul_data", 64'(data_out), 64'(w));
    chk("simul_no_overrun", 64'(overrun), 0);
    ready_val = 1'b1;
    cs_off();
    wait_drain();

    // Reset mid-frame with a word buffered.
    ready_val = 1'b0;
    send_word(32'h0000_0007, 0);
    for (int i = 0; i < 10; i++) put_bit(1'($urandom_range(0, 1)), 0);
    @(posedge clk); #1;
    reset = 1'b1; cs = 1'b0; bit_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_valid", 64'(data_valid), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_pulses", 64'({frame_error, overrun}), 0);

`ifdef SPI_RX_PARITY_EN
    ready_val = 1'b1;
    w = 32'h0000_0003;
    exp_ev.push_back(EV_PE);
    for (int i = WIDTH - 1; i >= 0; i--) put_bit(w[i], 0);
    put_bit(1'b1, 0);
    end_bits();
    chk("parity_bad_no_valid", 64'(data_valid), 0);
    exp_words.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) put_bit(w[i], 0);
    put_bit(1'b0, 0);
    end_bits();
    chk("parity_good_valid", 64'(data_valid), 1);
    cs_off();
    wait_drain();
`endif

    // Randomised frames with a random consumer.
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        nbits = $urandom_range(1, FLEN - 1);
        for (int i = 0; i < nbits; i++) put_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end_bits();
        exp_ev.push_back(EV_FE);
        cs_off();
      end else if (kind == 1) begin
        @(posedge clk); #1;
        cs = 1'b1;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        cs_off();
      end else begin
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) begin
          wait_buf_empty();
          w = WIDTH'($urandom);
          exp_words.push_back(w);
          send_word(w, 2);
        end
        cs_off();
      end
      idle_noise($urandom_range(1, 4));
    end

    rand_ready = 1'b0;
    ready_val  = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("events_drained", 64'(exp_ev.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
